// File: rtl/nonce_result_scanner.sv
// Scans NUM_NONCES H0 words in memory, tracks the smallest hash and writes a 3-word result record.
// Optional macro SCAN_STOP_ON_FIRST_EN: end the scan at the first sampled word below target.
`timescale 1ns/1ps

module nonce_result_scanner #(
    parameter int unsigned NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] input_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        found,
    output logic [15:0] best_nonce,
    output logic [31:0] best_hash
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DRAIN,
        WR0,
        WR1,
        WR2,
        FIN
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_NONCES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] base_addr;
    logic [15:0] res_addr;
    logic [31:0] target_q;
    logic [15:0] issue_cnt;
    logic [15:0] sample_cnt;
    logic        rd_v1;
    logic        rd_v2;

    logic        sample_en;
    logic        hit;
    logic        better;
    logic        last_issue;
    logic        last_sample;
    logic        stop_early;

    assign mem_clk = clk;

    // rd_v1/rd_v2 follow each issued address through the two-cycle memory read latency.
    always_comb begin
        sample_en   = rd_v2 && ((state == RD) || (state == DRAIN));
        hit         = sample_en && (mem_read_data < target_q);
        better      = sample_en && (mem_read_data < best_hash);
        last_issue  = (issue_cnt == LAST_IDX);
        last_sample = sample_en && (sample_cnt == LAST_IDX);
`ifdef SCAN_STOP_ON_FIRST_EN
        stop_early  = hit;
`else
        stop_early  = 1'b0;
`endif
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RD;
            RD: begin
                if (stop_early)      state_next = WR0;
                else if (last_issue) state_next = DRAIN;
            end
            DRAIN:   if (stop_early || last_sample) state_next = WR0;
            WR0:     state_next = WR1;
            WR1:     state_next = WR2;
            WR2:     state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done           <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            found          <= 1'b0;
            best_nonce     <= '0;
            best_hash      <= 32'hFFFF_FFFF;
            base_addr      <= '0;
            res_addr       <= '0;
            target_q       <= '0;
            issue_cnt      <= '0;
            sample_cnt     <= '0;
            rd_v1          <= 1'b0;
            rd_v2          <= 1'b0;
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;

            if ((state == IDLE) && start) begin
                base_addr  <= input_addr;
                res_addr   <= result_addr;
                target_q   <= target;
                found      <= 1'b0;
                best_hash  <= 32'hFFFF_FFFF;
                best_nonce <= '0;
                issue_cnt  <= '0;
                sample_cnt <= '0;
            end

            if ((state == RD) && !stop_early) begin
                mem_addr  <= base_addr + issue_cnt;
                issue_cnt <= issue_cnt + 16'd1;
                rd_v1     <= 1'b1;
            end else begin
                rd_v1 <= 1'b0;
            end
            // An early stop discards whatever reads are still in flight.
            rd_v2 <= rd_v1 && !stop_early;

            if (sample_en) begin
                sample_cnt <= sample_cnt + 16'd1;
`ifdef SCAN_STOP_ON_FIRST_EN
                if (hit) begin
                    best_hash  <= mem_read_data;
                    best_nonce <= sample_cnt;
                    found      <= 1'b1;
                end else if (better) begin
                    best_hash  <= mem_read_data;
                    best_nonce <= sample_cnt;
                end
`else
                if (better) begin
                    best_hash  <= mem_read_data;
                    best_nonce <= sample_cnt;
                end
                if (hit) found <= 1'b1;
`endif
            end

            case (state)
                WR0: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= res_addr;
                    mem_write_data <= {31'b0, found};
                end
                WR1: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= res_addr + 16'd1;
                    mem_write_data <= {16'b0, best_nonce};
                end
                WR2: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= res_addr + 16'd2;
                    mem_write_data <= best_hash;
                end
                FIN:     done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
